// File: rtl/register_file_scoreboard.sv
// ---------------------------------------------------------------------------
// register_file_scoreboard
//
// Register file with a per-register "pending" scoreboard bit, for an in-order
// issue pipeline. Issuing a producer reserves its destination register, which
// marks it pending. The writeback later stores the result and clears the
// pending bit. After reset the block walks through every register and loads
// it with its own index (INIT). It then raises ready and serves reads and
// writes (RUN).
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   address width, DEPTH = 2**ADDR_W registers
//   BYPASS   1 = a same-cycle writeback is forwarded to the read ports
//   ZERO_REG 1 = register 0 is hardwired to zero and is never pending
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   src1, src2   combinational read addresses
//   Dest_wb      writeback address
//   Result_WB    writeback data
//   writeBackEn  writeback enable
//   reserveEn    reserve enable, marks Dest_reserve as pending
//   Dest_reserve address to reserve
//   reg1, reg2   read data for src1 / src2
//   pend1, pend2 source register is awaiting writeback
//   ready        initialisation finished, operations accepted
// ---------------------------------------------------------------------------
module register_file_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic [ADDR_W-1:0] Dest_wb,
    input  logic [DATA_W-1:0] Result_WB,
    input  logic              writeBackEn,
    input  logic              reserveEn,
    input  logic [ADDR_W-1:0] Dest_reserve,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic              pend1,
    output logic              pend2,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]    pending_q, pending_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [DATA_W-1:0]   regs_d [DEPTH];

    logic                wb_ok;
    logic                res_ok;
    logic [ADDR_W-1:0]   src_a  [2];
    logic [DATA_W-1:0]   rdata  [2];
    logic                rpend  [2];

    // In ZERO_REG mode, register 0 accepts neither writebacks nor reserves.
    assign wb_ok  = writeBackEn && !(ZERO_REG && (Dest_wb == '0));
    assign res_ok = reserveEn && !(ZERO_REG && (Dest_reserve == '0));

    // Sequencing: INIT counts through every register and then hands over to
    // RUN. RUN is left only through reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Scoreboard. The reserve is applied after the writeback clear. When both
    // target the same register, the new producer keeps the register pending.
    always_comb begin
        pending_d = pending_q;
        if (state_q == RUN) begin
            if (wb_ok) begin
                pending_d[Dest_wb] = 1'b0;
            end
            if (res_ok) begin
                pending_d[Dest_reserve] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            pending_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Register array. Reset does not clear it. Its contents are rebuilt by
    // the INIT walk. The write is gated with rst so that a clock edge during
    // reset leaves the array untouched.
    always_comb begin
        regs_d = regs_q;
        if (rst) begin
            if (state_q == INIT) begin
                regs_d[cnt_q] = DATA_W'(cnt_q);
            end else if (wb_ok) begin
                regs_d[Dest_wb] = Result_WB;
            end
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // The two read ports are identical and independent. Outputs are forced
    // low in INIT, which also covers reset because reset holds the state in
    // INIT. Forwarding presents the same-cycle writeback as already
    // committed.
    assign src_a[0] = src1;
    assign src_a[1] = src2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = regs_q[src_a[p]];
            rpend[p] = pending_q[src_a[p]];
            if (BYPASS && wb_ok && (src_a[p] == Dest_wb)) begin
                rdata[p] = Result_WB;
                rpend[p] = 1'b0;
            end
            if (ZERO_REG && (src_a[p] == '0)) begin
                rdata[p] = '0;
                rpend[p] = 1'b0;
            end
            if (state_q != RUN) begin
                rdata[p] = '0;
                rpend[p] = 1'b0;
            end
        end
    end

    assign reg1  = rdata[0];
    assign reg2  = rdata[1];
    assign pend1 = rpend[0];
    assign pend2 = rpend[1];
    assign ready = (state_q == RUN);

endmodule
